// File: rtl/crack_pkg.sv
// Shared types and constants for the crack-engine scheduler.
package crack_pkg;

    localparam int KEY_W_DEF = 24;
    localparam int CT_AW     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ct_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester found scanning upward from ptr.
module ct_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Crack-engine scheduler: start/collect FSM plus round-robin sharing of the ciphertext port.
// Defining CRACK_SCHED_PERF_EN adds the perf_cycles RUN-cycle counter output.
import crack_pkg::*;

// state | meaning
// IDLE  | waiting for en while all engines are ready
// START | one-cycle start pulse to every engine
// RUN   | collecting engine completions, first valid key wins
// DONE  | one cycle with the result latched, then back to IDLE
module crack_sched #(
    parameter int NUM_ENG = 2,
    parameter int KEY_W   = KEY_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     rdy,
    output logic [KEY_W-1:0]         key,
    output logic                     key_valid,
    output logic [NUM_ENG-1:0]       eng_en,
    input  logic [NUM_ENG-1:0]       eng_rdy,
    output logic [NUM_ENG*KEY_W-1:0] eng_key_start,
    input  logic [NUM_ENG*KEY_W-1:0] eng_key,
    input  logic [NUM_ENG-1:0]       eng_key_valid,
    input  logic [NUM_ENG-1:0]       eng_ct_req,
    input  logic [NUM_ENG*CT_AW-1:0] eng_ct_addr,
    output logic [NUM_ENG-1:0]       eng_ct_gnt,
    output logic [NUM_ENG-1:0]       eng_ct_rvalid,
    output logic [7:0]               eng_ct_rddata,
    output logic [CT_AW-1:0]         ct_addr,
    input  logic [7:0]               ct_rddata
`ifdef CRACK_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    sched_state_t       state, state_nxt;
    logic               live;
    logic [KEY_W-1:0]   key_nxt, hit_key;
    logic               key_valid_nxt;
    logic [NUM_ENG-1:0] done_q, done_nxt;
    logic [NUM_ENG-1:0] seen_low, seen_low_nxt;
    logic [NUM_ENG-1:0] finish, hit;
    logic [NUM_ENG-1:0] arb_gnt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_key_start
        assign eng_key_start[gi*KEY_W +: KEY_W] = KEY_W'(gi);
    end

    // live holds rdy low until the first clock after reset release
    assign rdy    = live && (state == IDLE) && (&eng_rdy);
    assign finish = eng_rdy & seen_low & ~done_q;
    assign hit    = finish & eng_key_valid;

    always_comb begin
        hit_key = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (hit[i]) hit_key = eng_key[i*KEY_W +: KEY_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            done_q    <= '0;
            seen_low  <= '0;
        end else begin
            state     <= state_nxt;
            live      <= 1'b1;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
            done_q    <= done_nxt;
            seen_low  <= seen_low_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        key_nxt       = key;
        key_valid_nxt = key_valid;
        done_nxt      = done_q;
        seen_low_nxt  = seen_low;
        eng_en        = '0;
        unique case (state)
            IDLE: begin
                if (rdy && en) begin
                    state_nxt     = START;
                    key_valid_nxt = 1'b0;
                    done_nxt      = '0;
                    seen_low_nxt  = '0;
                end
            end
            START: begin
                eng_en       = '1;
                seen_low_nxt = ~eng_rdy;
                state_nxt    = RUN;
            end
            RUN: begin
                seen_low_nxt = seen_low | ~eng_rdy;
                done_nxt     = done_q | finish;
                if (|hit) begin
                    key_nxt       = hit_key;
                    key_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end else if (&(done_q | finish)) begin
                    key_nxt       = '0;
                    key_valid_nxt = 1'b0;
                    state_nxt     = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    ct_rr_arb #(
        .N     (NUM_ENG),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (eng_ct_req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // grant is combinational, so it must also drop the instant reset asserts
    assign eng_ct_gnt    = arb_gnt & {NUM_ENG{rst_n}};
    assign eng_ct_rddata = ct_rddata;

    always_comb begin
        ptr_nxt = ptr;
        ct_addr = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_ct_gnt[i]) begin
                ptr_nxt = PTR_W'((i + 1) % NUM_ENG);
                ct_addr = eng_ct_addr[i*CT_AW +: CT_AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            eng_ct_rvalid <= '0;
        end else begin
            ptr           <= ptr_nxt;
            eng_ct_rvalid <= eng_ct_gnt;
        end
    end

`ifdef CRACK_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (state == START) begin
            perf_cycles <= '0;
        end else if ((state == RUN) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crack_sched.sv
// Self-checking bench for crack_sched: table-driven searches, randomized searches and arbitration.
module tb_crack_sched;

    localparam int N  = 2;
    localparam int KW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            rdy;
    logic [KW-1:0]   key;
    logic            key_valid;
    logic [N-1:0]    eng_en;
    logic [N-1:0]    eng_rdy;
    logic [N*KW-1:0] eng_key_start;
    logic [N*KW-1:0] eng_key;
    logic [N-1:0]    eng_key_valid;
    logic [N-1:0]    eng_ct_req;
    logic [N*8-1:0]  eng_ct_addr;
    logic [N-1:0]    eng_ct_gnt;
    logic [N-1:0]    eng_ct_rvalid;
    logic [7:0]      eng_ct_rddata;
    logic [7:0]      ct_addr;
    logic [7:0]      ct_rddata;
`ifdef CRACK_SCHED_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    crack_sched #(.NUM_ENG(N), .KEY_W(KW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .rdy           (rdy),
        .key           (key),
        .key_valid     (key_valid),
        .eng_en        (eng_en),
        .eng_rdy       (eng_rdy),
        .eng_key_start (eng_key_start),
        .eng_key       (eng_key),
        .eng_key_valid (eng_key_valid),
        .eng_ct_req    (eng_ct_req),
        .eng_ct_addr   (eng_ct_addr),
        .eng_ct_gnt    (eng_ct_gnt),
        .eng_ct_rvalid (eng_ct_rvalid),
        .eng_ct_rddata (eng_ct_rddata),
        .ct_addr       (ct_addr),
        .ct_rddata     (ct_rddata)
`ifdef CRACK_SCHED_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            d0;
        int            d1;
        bit            v0;
        bit            v1;
        logic [KW-1:0] k0;
        logic [KW-1:0] k1;
        bit            exp_kv;
        logic [KW-1:0] exp_key;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         mptr   = 0;
    bit [N-1:0] pend   = '0;
    bit [N-1:0] prev_g = '0;
    logic [7:0] paddr [N];
    vec_t       tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine i drops ready for d cycles after START and reports at cycle d+1.
    // The earliest valid report wins, ties go to the lower index; no valid report ends at the last engine.
    function automatic void search_model(input vec_t s, output int tfin, output int tall,
                                         output bit kv, output logic [KW-1:0] kexp);
        int            d [N];
        bit            v [N];
        logic [KW-1:0] k [N];
        d = '{s.d0, s.d1};
        v = '{s.v0, s.v1};
        k = '{s.k0, s.k1};
        tall = 0;
        tfin = 1 << 30;
        kv   = 1'b0;
        kexp = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i] + 1 > tall) tall = d[i] + 1;
            if (v[i] && (d[i] + 1 < tfin)) begin
                tfin = d[i] + 1;
                kexp = k[i];
                kv   = 1'b1;
            end
        end
        if (!kv) tfin = tall;
    endfunction

    task automatic run_search(input vec_t s, input bit exp_kv, input logic [KW-1:0] exp_key);
        int            tfin, tall, trdy;
        bit            mkv;
        logic [KW-1:0] mkey;
        int            d [N];
        bit            v [N];
        search_model(s, tfin, tall, mkv, mkey);
        d    = '{s.d0, s.d1};
        v    = '{s.v0, s.v1};
        trdy = (tfin + 2 > tall) ? tfin + 2 : tall;
        @(posedge clk); #1;
        en            = 1'b1;
        eng_rdy       = '1;
        eng_key_valid = '0;
        eng_key       = {s.k1, s.k0};
        @(negedge clk);
        chk("rdy_before_start", rdy, 1);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        chk("start_eng_en", eng_en, 2'b11);
        chk("start_kv_clear", key_valid, 0);
        for (int c = 1; c <= trdy + 1; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                eng_rdy[i]       = (c > d[i]);
                eng_key_valid[i] = (c > d[i]) && v[i];
            end
            @(negedge clk);
            chk("run_eng_en", eng_en, 0);
            chk("run_rdy", rdy, (c >= trdy));
            chk("run_kv", key_valid, (exp_kv && (c >= tfin + 1)));
            if (c >= tfin + 1) chk("result_key", key, exp_key);
        end
    endtask

    task automatic arb_random(input int cycles);
        int         g;
        logic [7:0] rd;
        bit [N-1:0] expg;
        logic [7:0] expaddr;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 8'($urandom);
                end
            end
            eng_ct_req  = pend;
            eng_ct_addr = {paddr[1], paddr[0]};
            rd          = 8'($urandom);
            ct_rddata   = rd;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
            end
            expg    = '0;
            expaddr = '0;
            if (g >= 0) begin
                expg[g] = 1'b1;
                expaddr = paddr[g];
            end
            @(negedge clk);
            chk("arb_gnt", eng_ct_gnt, expg);
            chk("arb_ct_addr", ct_addr, expaddr);
            chk("arb_rvalid", eng_ct_rvalid, prev_g);
            chk("arb_rddata", eng_ct_rddata, rd);
            if (g >= 0) begin
                pend[g] = 1'b0;
                mptr    = (g + 1) % N;
            end
            prev_g = expg;
        end
        @(posedge clk); #1;
        pend       = '0;
        eng_ct_req = '0;
        @(negedge clk);
        chk("arb_rvalid_tail", eng_ct_rvalid, prev_g);
        prev_g = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          s;
        int            tf, ta;
        bit            mkv;
        logic [KW-1:0] mk;

        tbl[0] = '{d0:10, d1:2, v0:1, v1:1, k0:24'h00AAAA, k1:24'h00001B, exp_kv:1, exp_key:24'h00001B};
        tbl[1] = '{d0:3,  d1:3, v0:1, v1:1, k0:24'h000010, k1:24'h000011, exp_kv:1, exp_key:24'h000010};
        tbl[2] = '{d0:2,  d1:4, v0:0, v1:0, k0:24'h000055, k1:24'h000066, exp_kv:0, exp_key:24'h000000};
        tbl[3] = '{d0:5,  d1:1, v0:1, v1:0, k0:24'hABCDEF, k1:24'h123456, exp_kv:1, exp_key:24'hABCDEF};
        tbl[4] = '{d0:4,  d1:3, v0:1, v1:1, k0:24'h111111, k1:24'h222222, exp_kv:1, exp_key:24'h222222};
        tbl[5] = '{d0:1,  d1:7, v0:1, v1:0, k0:24'h000042, k1:24'h000077, exp_kv:1, exp_key:24'h000042};

        rst_n         = 1'b0;
        en            = 1'b0;
        eng_rdy       = '1;
        eng_key       = '0;
        eng_key_valid = '0;
        eng_ct_req    = 2'b11;
        eng_ct_addr   = {8'h09, 8'h05};
        ct_rddata     = 8'h00;
        paddr         = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", rdy, 0);
        chk("rst_key", key, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_gnt", eng_ct_gnt, 0);
        chk("rst_rvalid", eng_ct_rvalid, 0);
        chk("rst_ct_addr", ct_addr, 0);
        @(posedge clk); #1;
        eng_ct_req = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_first_clk", rdy, 0);
        chk("key_start", eng_key_start, {24'h000001, 24'h000000});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdy_after_first_clk", rdy, 1);

        for (int r = 0; r < 6; r++) run_search(tbl[r], tbl[r].exp_kv, tbl[r].exp_key);

        for (int r = 0; r < 25; r++) begin
            s.d0 = $urandom_range(1, 6);
            s.d1 = $urandom_range(1, 6);
            s.v0 = 1'($urandom);
            s.v1 = 1'($urandom);
            s.k0 = KW'($urandom);
            s.k1 = KW'($urandom);
            search_model(s, tf, ta, mkv, mk);
            s.exp_kv  = mkv;
            s.exp_key = mk;
            run_search(s, mkv, mk);
        end

        @(posedge clk); #1;
        eng_rdy = 2'b10;
        en      = 1'b1;
        @(negedge clk);
        chk("en_blocked_rdy", rdy, 0);
        @(posedge clk); #1;
        en      = 1'b0;
        eng_rdy = 2'b11;
        @(negedge clk);
        chk("en_ignored_eng_en", eng_en, 0);
        chk("en_ignored_rdy", rdy, 1);

        for (int c = 0; c < 5; c++) begin
            logic [7:0] rd;
            @(posedge clk); #1;
            eng_ct_req  = (c < 4) ? 2'b11 : 2'b00;
            eng_ct_addr = {8'h09, 8'h05};
            rd          = 8'($urandom);
            ct_rddata   = rd;
            @(negedge clk);
            if (c < 4) begin
                chk("alt_gnt", eng_ct_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
                chk("alt_ct_addr", ct_addr, (c % 2 == 0) ? 8'h05 : 8'h09);
            end else begin
                chk("alt_idle_gnt", eng_ct_gnt, 0);
                chk("alt_idle_addr", ct_addr, 0);
            end
            if (c == 0) chk("alt_rvalid", eng_ct_rvalid, 0);
            else        chk("alt_rvalid", eng_ct_rvalid, ((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_rddata", eng_ct_rddata, rd);
        end
        mptr   = 0;
        prev_g = '0;

        arb_random(200);

        run_search(tbl[0], tbl[0].exp_kv, tbl[0].exp_key);
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        eng_rdy = '0;
        @(posedge clk); #1;
        eng_ct_req  = 2'b11;
        eng_ct_addr = {8'h09, 8'h05};
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_gnt", eng_ct_gnt, 0);
        chk("midrun_kv", key_valid, 0);
        chk("midrun_key", key, 0);
        chk("midrun_rdy", rdy, 0);
        chk("midrun_eng_en", eng_en, 0);
        @(posedge clk); #1;
        eng_ct_req = '0;
        eng_rdy    = '1;
        #1 rst_n = 1'b1;
        mptr   = 0;
        prev_g = '0;
        @(negedge clk);
        chk("midrun_rdy_pre_clk", rdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrun_back_idle", rdy, 1);

        arb_random(60);
        run_search(tbl[3], tbl[3].exp_kv, tbl[3].exp_key);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
